// File: rtl/bp_if.sv
// Lookup, prediction and training signals shared between fetch/decode and the branch predictor.
interface bp_if #(
  parameter int DATA_W = 64,
  parameter int GHR_W  = 5
);
  logic              en;
  logic [DATA_W-1:0] lookup_pc;
  logic              pred_valid;
  logic              pred_hit;
  logic              pred_taken;
  logic [DATA_W-1:0] pred_target;
  logic [GHR_W-1:0]  pred_ghr;
  logic              upd_valid;
  logic [DATA_W-1:0] upd_pc;
  logic              upd_branch;
  logic              upd_jump;
  logic              upd_taken;
  logic [DATA_W-1:0] upd_target;
  logic [GHR_W-1:0]  upd_ghr;

  modport master (
    output en, lookup_pc, upd_valid, upd_pc, upd_branch, upd_jump, upd_taken, upd_target, upd_ghr,
    input  pred_valid, pred_hit, pred_taken, pred_target, pred_ghr
  );

  modport slave (
    input  en, lookup_pc, upd_valid, upd_pc, upd_branch, upd_jump, upd_taken, upd_target, upd_ghr,
    output pred_valid, pred_hit, pred_taken, pred_target, pred_ghr
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped saturating-counter pattern table plus tagged BTB with a registered lookup.
// Optional gshare counter indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 32,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 5
) (
  input logic clk,
  input logic arst_n,
  bp_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [DATA_W-1:0] target_q [ENTRIES];
  logic [ENTRIES-1:0] jump_q;

  logic              pred_valid_q;
  logic              pred_hit_q;
  logic              pred_taken_q;
  logic [DATA_W-1:0] pred_target_q;
  logic [GHR_W-1:0]  pred_ghr_q;

  logic [IDX_W-1:0]  lkIdx;
  logic [IDX_W-1:0]  lkCtrIdx;
  logic [TAG_W-1:0]  lkTag;
  logic [GHR_W-1:0]  lkGhr;
  logic              lkHit;
  logic              lkTaken;
  logic [DATA_W-1:0] lkTarget;

  logic [IDX_W-1:0]  updIdx;
  logic [IDX_W-1:0]  updCtrIdx;
  logic [TAG_W-1:0]  updTag;
  logic              doBranch;
  logic              doJump;
  logic              ctrWrite;
  logic              btbWrite;
  logic [CTR_W-1:0]  ctrOld;
  logic [CTR_W-1:0]  ctr_d;

  assign lkIdx  = bus.lookup_pc[IDX_W+1:2];
  assign lkTag  = bus.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign updIdx = bus.upd_pc[IDX_W+1:2];
  assign updTag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Both flags set is illegal; the jump wins so the entry still ends up consistent.
  assign doJump   = bus.upd_valid && bus.upd_jump;
  assign doBranch = bus.upd_valid && bus.upd_branch && !bus.upd_jump;
  assign ctrWrite = doJump || doBranch;
  assign btbWrite = doJump || (doBranch && bus.upd_taken);

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;

  assign lkCtrIdx  = lkIdx ^ IDX_W'(ghr_q);
  assign updCtrIdx = updIdx ^ IDX_W'(bus.upd_ghr);
  assign lkGhr     = ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (doBranch) begin
      ghr_d = (ghr_q << 1) | GHR_W'(bus.upd_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ghr_q <= '0;
    end else if (bus.en) begin
      ghr_q <= ghr_d;
    end
  end
`else
  logic unusedGhr;

  assign lkCtrIdx  = lkIdx;
  assign updCtrIdx = updIdx;
  assign lkGhr     = '0;
  assign unusedGhr = ^bus.upd_ghr;
`endif

  logic unusedUpdPc;
  assign unusedUpdPc = ^bus.upd_pc;

  assign lkHit    = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
  assign lkTaken  = lkHit && (jump_q[lkIdx] || ctrOldLk());
  assign lkTarget = lkTaken ? target_q[lkIdx] : bus.lookup_pc + DATA_W'(4);

  function automatic logic ctrOldLk();
    return ctr_q[lkCtrIdx][CTR_W-1];
  endfunction

  assign ctrOld = ctr_q[updCtrIdx];

  always_comb begin
    ctr_d = ctrOld;
    if (doJump) begin
      ctr_d = CTR_MAX;
    end else if (doBranch) begin
      if (bus.upd_taken) begin
        if (ctrOld != CTR_MAX) ctr_d = ctrOld + CTR_W'(1);
      end else begin
        if (ctrOld != '0) ctr_d = ctrOld - CTR_W'(1);
      end
    end
  end

  // The lookup reads the arrays before this edge's update lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RST;
      end
      valid_q       <= '0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_ghr_q    <= '0;
    end else if (bus.en) begin
      pred_valid_q  <= 1'b1;
      pred_hit_q    <= lkHit;
      pred_taken_q  <= lkTaken;
      pred_target_q <= lkTarget;
      pred_ghr_q    <= lkGhr;
      if (ctrWrite) ctr_q[updCtrIdx] <= ctr_d;
      if (btbWrite) valid_q[updIdx] <= 1'b1;
    end
  end

  // BTB payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (arst_n && bus.en && btbWrite) begin
      tag_q[updIdx]    <= updTag;
      target_q[updIdx] <= bus.upd_target;
      jump_q[updIdx]   <= doJump;
    end
  end

  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_hit    = pred_hit_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.pred_target = pred_target_q;
  assign bus.pred_ghr    = pred_ghr_q;

  illegalUpdate: assert property (@(posedge clk) disable iff (!arst_n)
    !(bus.en && bus.upd_valid && bus.upd_branch && bus.upd_jump));

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed lookups push expectations, a negedge monitor pops and compares.
// Gshare scenario runs when BP_GSHARE_EN is defined; otherwise the default-build scenario runs.
module tb_branch_predictor;
  localparam int DATA_W = 64;
  localparam int GHR_W  = 5;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [63:0] target;
    logic [4:0]  ghr;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic chkNext = 1'b0;
  logic chkPipe = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t expQ[$];
  string nameQ[$];
  exp_t curExp;
  string curName;

  bp_if #(.DATA_W(DATA_W), .GHR_W(GHR_W)) bus ();

  branch_predictor #(
    .DATA_W(DATA_W), .ENTRIES(32), .CTR_W(2), .TAG_W(8), .GHR_W(GHR_W)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // A tagged lookup sampled at an enabled, non-reset edge is checked at the following negedge.
  always @(posedge clk) chkPipe <= chkNext && bus.en && arst_n;

  always @(negedge clk) begin
    if (chkPipe) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: got a prediction, expected an empty queue");
      end else begin
        curExp  = expQ.pop_front();
        curName = nameQ.pop_front();
        checkOutput({curName, ".valid"},  {63'd0, bus.pred_valid}, 64'd1);
        checkOutput({curName, ".hit"},    {63'd0, bus.pred_hit},   {63'd0, curExp.hit});
        checkOutput({curName, ".taken"},  {63'd0, bus.pred_taken}, {63'd0, curExp.taken});
        checkOutput({curName, ".target"}, bus.pred_target,         curExp.target);
        checkOutput({curName, ".ghr"},    {59'd0, bus.pred_ghr},   {59'd0, curExp.ghr});
      end
    end
  end

  task automatic expectLookup(input string name, input logic [63:0] pc, input logic hit,
                              input logic taken, input logic [63:0] target, input logic [4:0] ghr);
    exp_t e;
    e.hit = hit;
    e.taken = taken;
    e.target = target;
    e.ghr = ghr;
    bus.lookup_pc = pc;
    chkNext = 1'b1;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic setUpdate(input logic [63:0] pc, input logic br, input logic jp,
                           input logic tk, input logic [63:0] target, input logic [4:0] ghr);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_branch = br;
    bus.upd_jump   = jp;
    bus.upd_taken  = tk;
    bus.upd_target = target;
    bus.upd_ghr    = ghr;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    chkNext        = 1'b0;
    bus.lookup_pc  = 64'hF00;
    bus.upd_valid  = 1'b0;
    bus.upd_branch = 1'b0;
    bus.upd_jump   = 1'b0;
    bus.upd_taken  = 1'b0;
    bus.upd_ghr    = '0;
  endtask

  task automatic branch(input logic [63:0] pc, input logic tk, input logic [63:0] target);
    setUpdate(pc, 1'b1, 1'b0, tk, target, 5'd0);
    applyStimulus();
  endtask

  task automatic look(input string name, input logic [63:0] pc, input logic hit,
                      input logic taken, input logic [63:0] target, input logic [4:0] ghr);
    expectLookup(name, pc, hit, taken, target, ghr);
    applyStimulus();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.en = 1'b1;
    bus.lookup_pc = 64'h40;
    bus.upd_pc = '0;
    bus.upd_target = '0;
    applyStimulus();
    bus.lookup_pc = 64'h40;
    applyStimulus();
    checkOutput("reset.valid",  {63'd0, bus.pred_valid}, 64'd0);
    checkOutput("reset.hit",    {63'd0, bus.pred_hit},   64'd0);
    checkOutput("reset.taken",  {63'd0, bus.pred_taken}, 64'd0);
    checkOutput("reset.target", bus.pred_target,         64'd0);
    checkOutput("reset.ghr",    {59'd0, bus.pred_ghr},   64'd0);

    arst_n = 1'b1;
    look("cold", 64'h100, 1'b0, 1'b0, 64'h104, 5'd0);

`ifdef BP_GSHARE_EN
    setUpdate(64'h0, 1'b1, 1'b0, 1'b1, 64'h500, 5'h15);
    applyStimulus();
    branch(64'h7C, 1'b1, 64'h600);
    branch(64'h7C, 1'b0, 64'h600);
    branch(64'h7C, 1'b1, 64'h600);
    branch(64'h7C, 1'b0, 64'h600);
    branch(64'h7C, 1'b1, 64'h600);
    look("gs_hist", 64'h0, 1'b1, 1'b1, 64'h500, 5'h15);
    for (int i = 0; i < 5; i++) branch(64'h7C, 1'b0, 64'h600);
    look("gs_zero", 64'h0, 1'b1, 1'b0, 64'h4, 5'd0);
`else
    branch(64'h40, 1'b1, 64'h80);
    look("train_t1", 64'h40, 1'b1, 1'b1, 64'h80, 5'd0);
    look("alias", 64'h1040, 1'b0, 1'b0, 64'h1044, 5'd0);
    branch(64'h40, 1'b1, 64'h80);
    branch(64'h40, 1'b1, 64'h80);
    branch(64'h40, 1'b0, 64'h80);
    look("nt1", 64'h40, 1'b1, 1'b1, 64'h80, 5'd0);
    branch(64'h40, 1'b0, 64'h80);
    look("nt2", 64'h40, 1'b1, 1'b0, 64'h44, 5'd0);
    branch(64'h40, 1'b0, 64'h80);
    branch(64'h40, 1'b0, 64'h80);
    branch(64'h40, 1'b1, 64'h80);
    look("floor", 64'h40, 1'b1, 1'b0, 64'h44, 5'd0);
    branch(64'h40, 1'b1, 64'h80);
    look("rise", 64'h40, 1'b1, 1'b1, 64'h80, 5'd0);

    setUpdate(64'h200, 1'b0, 1'b1, 1'b0, 64'h1000, 5'd0);
    applyStimulus();
    look("jump", 64'h200, 1'b1, 1'b1, 64'h1000, 5'd0);
    look("jump_alias", 64'h100, 1'b0, 1'b0, 64'h104, 5'd0);
    branch(64'h100, 1'b0, 64'h300);
    branch(64'h100, 1'b1, 64'h300);
    look("jump_ctr", 64'h100, 1'b1, 1'b1, 64'h300, 5'd0);
    look("overwrite", 64'h200, 1'b0, 1'b0, 64'h204, 5'd0);

    bus.en = 1'b0;
    setUpdate(64'h40, 1'b1, 1'b0, 1'b0, 64'h80, 5'd0);
    bus.lookup_pc = 64'h200;
    applyStimulus();
    setUpdate(64'h0C, 1'b1, 1'b0, 1'b1, 64'h900, 5'd0);
    bus.lookup_pc = 64'h100;
    applyStimulus();
    checkOutput("hold.valid",  {63'd0, bus.pred_valid}, 64'd1);
    checkOutput("hold.hit",    {63'd0, bus.pred_hit},   64'd0);
    checkOutput("hold.target", bus.pred_target,         64'h204);
    bus.en = 1'b1;
    look("hold_ctr", 64'h40, 1'b1, 1'b1, 64'h80, 5'd0);
    look("hold_btb", 64'h0C, 1'b0, 1'b0, 64'h10, 5'd0);

    setUpdate(64'h0C, 1'b0, 1'b0, 1'b1, 64'h900, 5'd0);
    applyStimulus();
    look("noflag", 64'h0C, 1'b0, 1'b0, 64'h10, 5'd0);

    setUpdate(64'h40, 1'b1, 1'b0, 1'b0, 64'h80, 5'd0);
    look("same_old", 64'h40, 1'b1, 1'b1, 64'h80, 5'd0);
    look("same_new", 64'h40, 1'b1, 1'b0, 64'h44, 5'd0);

    look("pre_reset", 64'h40, 1'b1, 1'b0, 64'h44, 5'd0);
    arst_n = 1'b0;
    bus.lookup_pc = 64'h40;
    applyStimulus();
    checkOutput("midreset.valid",  {63'd0, bus.pred_valid}, 64'd0);
    checkOutput("midreset.target", bus.pred_target,         64'd0);
    arst_n = 1'b1;
    look("post_reset", 64'h40, 1'b0, 1'b0, 64'h44, 5'd0);
`endif

    applyStimulus();
    applyStimulus();
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised successor to the fixed 32-entry history table and target buffer in the five-stage RISC-V core, merged into a single block. It combines a direct-mapped pattern table of saturating counters with a tagged branch target buffer. It sits beside the program counter: the fetch PC is looked up, and the registered prediction arrives in step with the IF/ID register. Resolved branches and jumps from ID write back training updates.

## Interface
- DATA_W, 64: PC and target width.
- ENTRIES, 32: table depth; power of two, at least 4. IDX_W = log2(ENTRIES).
- CTR_W, 2: saturating counter width, 1..4.
- TAG_W, 8: BTB tag width; tag = pc[IDX_W+TAG_W+1 : IDX_W+2].
- GHR_W, 5: global history width, at most IDX_W; used only with the Configuration macro.
- clk  in  1  clock; all state changes on its rising edge.
- arst_n  in  1  reset, synchronous, active-low.
- en  in  1  global enable; when 0, no state changes and outputs hold.
- lookup_pc  in  DATA_W  fetch PC to predict.
- pred_valid  out  1  prediction for the previous cycle's lookup_pc is on the pred_* outputs.
- pred_hit  out  1  BTB valid and tag match.
- pred_taken  out  1  predicted redirect.
- pred_target  out  DATA_W  next PC: the stored target if pred_taken, else lookup_pc+4.
- pred_ghr  out  GHR_W  history snapshot used for this prediction; 0 without the macro.
- upd_valid  in  1  training update strobe.
- upd_pc  in  DATA_W  PC of the resolved instruction.
- upd_branch  in  1  conditional branch resolved.
- upd_jump  in  1  unconditional jump resolved; upd_branch and upd_jump are mutually exclusive.
- upd_taken  in  1  branch outcome; ignored for jumps.
- upd_target  in  DATA_W  resolved target.
- upd_ghr  in  GHR_W  the pred_ghr that accompanied this instruction's prediction.

## Operation
- Index: idx = pc[IDX_W+1:2]. Bits [1:0] are ignored.
- Entry state:
  - ctr[CTR_W]: reset value 2^(CTR_W-1)-1, i.e. weakly not-taken.
  - valid, which resets to 0.
  - tag, target and is_jump, none of which are reset.
- Lookup, registered, when en=1:
  - pred_hit = valid[idx] && tag[idx]==tag(lookup_pc).
  - pred_taken = pred_hit && (is_jump[idx] || ctr[idx] MSB).
  - pred_target = target[idx] if pred_taken, else lookup_pc+4, truncated modulo 2^DATA_W.
  - pred_valid is 1.
- Update with upd_valid && upd_branch && en:
  - ctr increments on taken and saturates at 2^CTR_W-1; it decrements on not-taken and saturates at 0.
  - If taken, BTB entry is written: valid=1, tag, target=upd_target, is_jump=0.
  - A not-taken branch leaves the BTB untouched.
- Update with upd_valid && upd_jump && en: BTB entry is written with is_jump=1, and ctr is set to its maximum.
- Neither flag set: the update is ignored.
- Aliasing: a tag mismatch gives pred_hit=0. Counters are untagged and shared between aliases; a BTB write overwrites the previous owner.
- Lookup and update to the same index in the same cycle: read-before-write. The lookup sees pre-update state; the next lookup sees the new state.
- upd_valid with upd_branch and upd_jump both set is illegal; the assertion fires, and the RTL treats it as a jump.

## Timing
- Lookup latency is 1 cycle: lookup_pc sampled at edge N gives pred_* valid after edge N. Throughput is one lookup per cycle.
- Updates are visible to a lookup sampled at edge N+1 or later.
- Reset (arst_n=0 at an edge, en ignored):
  - pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0, pred_ghr=0.
  - All valid bits 0, all counters at their reset value, GHR=0.
  - Reset mid-operation discards any in-flight prediction. pred_valid returns to 1 one cycle after arst_n=1 with en=1.
- en=0: pred_valid holds its previous value, as do all other outputs and all state.

## Configuration
- BP_GSHARE_EN defined:
  - A GHR_W-bit global history register shifts in upd_taken at its LSB on every branch update. Jumps are not shifted in.
  - Lookup counter index is idx ^ {0, GHR}, and pred_ghr is the GHR sampled with the lookup.
  - Update counter index is upd idx ^ {0, upd_ghr}.
  - The BTB always uses the plain idx.
- Undefined: no GHR flop, counter index = idx, pred_ghr ties to 0, upd_ghr is ignored.

## Test plan
- Cold start: after reset, lookup 0x100 gives pred_valid=1, hit=0, taken=0, target=0x104.
- Branch training, ENTRIES=32, CTR_W=2:
  - Taken update at 0x40 with target 0x80 moves ctr 01→10; lookup 0x40 gives hit=1, taken=1, target 0x80.
  - Three not-taken updates take ctr 11→00 (starting from 11 after a second taken update). The lookup then gives taken=0 and target 0x44, and a fourth not-taken leaves ctr at 00.
- Alias: after 0x40 is trained, lookup 0x1040 (same idx, different tag) gives hit=0, taken=0, target 0x1044.
- Jump: update at 0x200 with target 0x1000; the next lookup of 0x200 gives taken=1, target 0x1000 with no warm-up.
- Hazards:
  - en=0 with upd_valid set leaves the state unchanged.
  - Same-cycle lookup and update of 0x40 returns the old prediction; a repeat of the lookup returns the new one.
- BP_GSHARE_EN, GHR_W=5: history 10101, then a branch at 0x0 trained taken with upd_ghr=10101. Lookup 0x0 uses counter idx 0x15 and returns taken; with GHR=0 it reads idx 0 and returns not-taken.
